fx_sched: RTL and testbench
===========================

// Module: fx_sched
// PURPOSE
//  Per-frame scheduler that time-shares one external effect engine across NUM_STAGES stages x 2 channels.
//  Captures each stereo frame from the I2S RX side and issues jobs in order S0L,S0R,S1L,S1R,...
//  Chains each stage output into the next stage. Returns the result to the I2S TX side at a fixed slot.
//  TX loads therefore land only in the transmitter's safe window (first sclk of a frame).
// PARAMETERS
//  NUM_STAGES  4    effect stages in chain (1..8)
//  TX_SLOT     508  mclk cycles from accepted rx_vld to tx_vld (= frame 512 - rx offset 4)
// PORTS
//  mclk           in   1              clock (22.579MHz)
//  rst            in   1              reset; synchronous, active-high
//  rx_data        in   sample_t       stereo frame from i2s RX, valid with rx_vld
//  rx_vld         in   1              1-cycle pulse, once per 512 mclk
//  tx_data        out  sample_t       processed frame to i2s TX
//  tx_vld         out  1              1-cycle pulse, TX_SLOT cycles after frame start
//  bypass_mask    in   NUM_STAGES     bit s=1: stage s skipped; sampled at frame start
//  fx_req_vld     out  1              job request valid
//  fx_req_rdy     in   1              engine accepts request
//  fx_req_stage   out  STG_W          stage index of job
//  fx_req_ch      out  1              0=left, 1=right
//  fx_req_data    out  SAMPLE_W       input sample of job
//  fx_rsp_vld     in   1              engine result valid (1-cycle)
//  fx_rsp_data    in   SAMPLE_W       engine result
//  busy           out  1              frame in progress (not IDLE)
//  timeout        out  1              1-cycle pulse: deadline hit before chain finished
//  frame_err      out  1              1-cycle pulse: rx_vld arrived while frame active
// BEHAVIOUR
//  Reset: all outputs 0. tx_data='0. FSM=IDLE. Slot counter cleared. No outstanding job.
//  Frame start: rx_vld in IDLE latches rx_data into dry and work regs. Latches bypass_mask.
//   Loads slot_cnt=1. Enters NEXT.
//  FSM states:
//   IDLE   wait for rx_vld.
//   NEXT   pick next job (stage-major, L before R). Bypassed stage: both jobs skipped, 1 cycle per stage.
//          No jobs left -> DONE. Otherwise -> ISSUE.
//   ISSUE  fx_req_vld=1. Stage, ch and data are held stable until fx_req_vld & fx_req_rdy.
//          Handshake -> WAIT.
//   WAIT   single outstanding job. fx_rsp_vld writes fx_rsp_data into work[ch] -> NEXT.
//   DONE   hold work regs until slot.
//   DRAIN  post-timeout: wait for outstanding fx_rsp_vld, discard it -> DONE.
//  Data: results stored raw, full SAMPLE_W width. No saturation or rounding here.
//  Stage s+1 job input = stage s result for same channel.
//  Slot: slot_cnt increments every cycle while not IDLE.
//   At slot_cnt==TX_SLOT: tx_vld=1 for one cycle. tx_data takes the registered value in the same cycle.
//   Source is work regs if DONE. Otherwise dry regs plus timeout=1.
//   Then IDLE, or DRAIN if a job is in WAIT.
//   An un-handshaken ISSUE is withdrawn; fx_req_vld drops the next cycle.
//  Latency: tx_vld exactly TX_SLOT cycles after rx_vld in all cases (bypass, timeout, normal).
//  All-bypass: no fx_req, tx = input frame.
//  rx_vld while active (not IDLE/DRAIN, before slot): frame_err=1 and current frame dropped (no tx_vld).
//   If a job is outstanding, go to DRAIN first.
//   The new frame is latched into a 1-deep pending reg and starts on exit of DRAIN, or immediately.
//   slot_cnt restarts from that rx_vld.
//  rx_vld in DRAIN: latched into pending reg, no frame_err. A second one in DRAIN overwrites pending.
//  rx_vld in same cycle as slot: tx_vld issued first, new frame starts that cycle.
//  fx_rsp_vld outside WAIT/DRAIN: ignored.
//  fx_req_rdy with fx_req_vld=0: no effect.
//  rst mid-operation: next cycle all outputs 0. Outstanding job forgotten. The engine shares rst.
// STRUCTURE
//  sample_pkg additions:
//   SAMPLE_W=24, FRAME_MCLK=512.
//   typedef enum {CH_L,CH_R} chan_e.
//   typedef struct {stage, chan_e ch} fx_job_t.
//   typedef enum fx_sched_state_e.
//  Sub-module fx_slot_timer: 9-bit slot counter with start/restart/clear and slot_hit pulse.
//  FSM, job sequencer and data regs stay in fx_sched.
// TESTING
//  1. mask=4'hF; rx lc=24'h123456, rc=24'hABCDEF -> no fx_req_vld; tx_vld at +508, tx equal to input, timeout=0.
//  2. mask=0; engine +1, 3-cycle latency, rdy=1 -> 8 reqs in order S0L,S0R..S3R; tx lc=24'h12345A, rc=24'hABCDF3 at +508.
//  3. mask=4'b0101 -> only stage 1,3 jobs issued; rdy low 100 cycles on first -> req fields stable, result +2 per channel.
//  4. Engine latency 100 cycles, mask=0 -> timeout pulse at +508, tx = dry frame, late rsp discarded.
//     Next frame (engine fixed) processes correctly.
//  5. rst asserted during WAIT -> all outputs 0 next cycle; stray fx_rsp_vld ignored; next rx_vld processed normally.
//  6. Second rx_vld at +300 -> frame_err pulse, no tx for first frame; tx_vld at +508 from second rx_vld.

Source files
------------

// File: rtl/sample_pkg.sv
// Shared audio sample types plus the effect-scheduler job and state types.
package sample_pkg;
  localparam int SAMPLE_W   = 24;
  localparam int FRAME_MCLK = 512;
  localparam int STG_W      = 3;
  localparam int MASK_W     = 1 << STG_W;

  typedef struct packed {
    logic [SAMPLE_W-1:0] lc;
    logic [SAMPLE_W-1:0] rc;
  } sample_t;

  typedef enum logic {CH_L = 1'b0, CH_R = 1'b1} chan_e;

  typedef struct packed {
    logic [STG_W-1:0] stage;
    chan_e            ch;
  } fx_job_t;

  typedef enum logic [2:0] {
    S_IDLE, S_NEXT, S_ISSUE, S_WAIT, S_DONE, S_DRAIN
  } fx_sched_state_e;
endpackage

// File: rtl/fx_slot_timer.sv
// Frame slot counter: (re)starts at 1 on start, raises slot_hit one cycle before the TX slot.
module fx_slot_timer #(
  parameter int TX_SLOT = 508
) (
  input  logic mclk,
  input  logic rst,
  input  logic start,
  input  logic clr,
  output logic slot_hit,
  output logic run
);
  logic [8:0] slot_cnt;

  always_ff @(posedge mclk) begin
    if (rst) begin
      slot_cnt <= '0;
      run      <= 1'b0;
    end else if (start) begin
      slot_cnt <= 9'd1;
      run      <= 1'b1;
    end else if (clr) begin
      slot_cnt <= '0;
      run      <= 1'b0;
    end else if (run) begin
      slot_cnt <= slot_cnt + 9'd1;
    end
  end

  // tx outputs are registered, so the hit is raised one count early to land them on TX_SLOT
  assign slot_hit = run && (slot_cnt == 9'(TX_SLOT - 1));
endmodule

// File: rtl/fx_sched.sv
// Time-shares one effect engine over NUM_STAGES x 2 channel jobs per stereo frame,
// returning the result at a fixed slot after the frame's rx_vld.
module fx_sched
  import sample_pkg::*;
#(
  parameter int NUM_STAGES = 4,
  parameter int TX_SLOT    = 508
) (
  input  logic                  mclk,
  input  logic                  rst,
  input  sample_t               rx_data,
  input  logic                  rx_vld,
  output sample_t               tx_data,
  output logic                  tx_vld,
  input  logic [NUM_STAGES-1:0] bypass_mask,
  output logic                  fx_req_vld,
  input  logic                  fx_req_rdy,
  output logic [STG_W-1:0]      fx_req_stage,
  output logic                  fx_req_ch,
  output logic [SAMPLE_W-1:0]   fx_req_data,
  input  logic                  fx_rsp_vld,
  input  logic [SAMPLE_W-1:0]   fx_rsp_data,
  output logic                  busy,
  output logic                  timeout,
  output logic                  frame_err
);
  fx_sched_state_e   st, nxt;
  sample_t           dry, work;
  logic [MASK_W-1:0] mask;
  fx_job_t           job;
  logic              chain_end, pend;
  logic              slot_hit, slot_run;
  logic              rsp_wr, skip, outst_nxt, err_go;

  fx_slot_timer #(.TX_SLOT(TX_SLOT)) u_tmr (
    .mclk     (mclk),
    .rst      (rst),
    .start    (rx_vld),
    .clr      (slot_hit),
    .slot_hit (slot_hit),
    .run      (slot_run)
  );

  // a job is still in flight at the engine after this edge
  assign outst_nxt = (st == S_ISSUE && fx_req_rdy) ||
                     ((st == S_WAIT || st == S_DRAIN) && !fx_rsp_vld);
  assign err_go    = rx_vld && slot_run && !slot_hit && (st != S_DRAIN);

  always_ff @(posedge mclk) begin
    if (rst) st <= S_IDLE;
    else     st <= nxt;
  end

  always_comb begin
    nxt    = st;
    rsp_wr = 1'b0;
    skip   = 1'b0;
    unique case (st)
      S_IDLE:  ;
      S_NEXT:  if (chain_end)            nxt  = S_DONE;
               else if (mask[job.stage]) skip = 1'b1;
               else                      nxt  = S_ISSUE;
      S_ISSUE: if (fx_req_rdy) nxt = S_WAIT;
      S_WAIT:  if (fx_rsp_vld) begin
                 rsp_wr = 1'b1;
                 nxt    = S_NEXT;
               end
      S_DONE:  if (!slot_run) nxt = S_IDLE;
      S_DRAIN: if (fx_rsp_vld) nxt = pend ? S_NEXT : S_DONE;
      default: nxt = S_IDLE;
    endcase
    if (slot_hit) nxt = outst_nxt ? S_DRAIN : S_IDLE;
    // a new frame always wins; it waits out any in-flight job in DRAIN
    if (rx_vld)   nxt = outst_nxt ? S_DRAIN : S_NEXT;
  end

  always_ff @(posedge mclk) begin
    if (rst) begin
      dry       <= '0;
      work      <= '0;
      mask      <= '0;
      job       <= '0;
      chain_end <= 1'b0;
      pend      <= 1'b0;
      tx_data   <= '0;
      tx_vld    <= 1'b0;
      timeout   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      tx_vld    <= slot_hit;
      timeout   <= slot_hit && (st != S_DONE);
      frame_err <= err_go;
      if (slot_hit) tx_data <= (st == S_DONE) ? work : dry;
      // dry/work double as the pending frame store while draining: drained results are discarded
      if (rx_vld) begin
        dry       <= rx_data;
        work      <= rx_data;
        mask      <= MASK_W'(bypass_mask);
        job       <= '0;
        chain_end <= 1'b0;
        pend      <= outst_nxt;
      end else begin
        if (slot_hit || (st == S_DRAIN && fx_rsp_vld)) pend <= 1'b0;
        if (rsp_wr) begin
          if (job.ch == CH_R) work.rc <= fx_rsp_data;
          else                work.lc <= fx_rsp_data;
        end
        if (rsp_wr || skip) begin
          if (skip || job.ch == CH_R) begin
            job.ch <= CH_L;
            if (job.stage == STG_W'(NUM_STAGES - 1)) chain_end <= 1'b1;
            else                                     job.stage <= job.stage + STG_W'(1);
          end else begin
            job.ch <= CH_R;
          end
        end
      end
    end
  end

  assign fx_req_vld   = (st == S_ISSUE);
  assign fx_req_stage = job.stage;
  assign fx_req_ch    = logic'(job.ch);
  assign fx_req_data  = (job.ch == CH_R) ? work.rc : work.lc;
  assign busy         = (st != S_IDLE);
endmodule

// File: tb/tb_fx_sched.sv
// Directed + randomized bench for fx_sched with a latency-programmable engine model.
module tb_fx_sched;
  import sample_pkg::*;
  localparam int NS   = 4;
  localparam int SLOT = 508;

  logic mclk = 1'b0;
  logic rst  = 1'b1;
  always #5 mclk = ~mclk;

  sample_t             rx_data = '0;
  sample_t             tx_data;
  logic                rx_vld = 1'b0;
  logic                tx_vld;
  logic [NS-1:0]       bypass_mask = '0;
  logic                fx_req_vld, fx_req_rdy, fx_req_ch, fx_rsp_vld;
  logic                busy, timeout, frame_err;
  logic [STG_W-1:0]    fx_req_stage;
  logic [SAMPLE_W-1:0] fx_req_data, fx_rsp_data;

  int total = 0;
  int bad   = 0;

  int                  eng_lat = 3;
  logic [SAMPLE_W-1:0] eng_inc = 24'd1;
  logic                e_busy, e_vld;
  int                  e_cnt;
  logic [SAMPLE_W-1:0] e_res;
  logic                stray = 1'b0;
  logic                rdy_dir = 1'b1, rdy_rnd_en = 1'b0, rdy_rnd = 1'b0;

  assign fx_req_rdy  = rdy_rnd_en ? rdy_rnd : rdy_dir;
  assign fx_rsp_vld  = e_vld | stray;
  assign fx_rsp_data = stray ? 24'hDEAD00 : e_res;

  fx_sched #(.NUM_STAGES(NS), .TX_SLOT(SLOT)) dut (
    .mclk(mclk), .rst(rst), .rx_data(rx_data), .rx_vld(rx_vld),
    .tx_data(tx_data), .tx_vld(tx_vld), .bypass_mask(bypass_mask),
    .fx_req_vld(fx_req_vld), .fx_req_rdy(fx_req_rdy), .fx_req_stage(fx_req_stage),
    .fx_req_ch(fx_req_ch), .fx_req_data(fx_req_data), .fx_rsp_vld(fx_rsp_vld),
    .fx_rsp_data(fx_rsp_data), .busy(busy), .timeout(timeout), .frame_err(frame_err)
  );

  // engine: result = input + eng_inc, eng_lat cycles after the handshake
  always @(posedge mclk) begin
    if (rst) begin
      e_busy <= 1'b0;
      e_cnt  <= 0;
      e_vld  <= 1'b0;
      e_res  <= '0;
    end else begin
      e_vld <= 1'b0;
      if (e_busy) begin
        if (e_cnt <= 1) begin
          e_vld  <= 1'b1;
          e_busy <= 1'b0;
        end else begin
          e_cnt <= e_cnt - 1;
        end
      end
      if (fx_req_vld && fx_req_rdy) begin
        e_busy <= 1'b1;
        e_cnt  <= eng_lat;
        e_res  <= fx_req_data + eng_inc;
      end
    end
  end

  always @(negedge mclk) rdy_rnd <= 1'($urandom_range(0, 1));

  typedef struct packed {
    logic [STG_W-1:0]    stg;
    logic                ch;
    logic [SAMPLE_W-1:0] d;
  } rec_t;
  rec_t rlog[$];

  always @(posedge mclk)
    if (!rst && fx_req_vld && fx_req_rdy) rlog.push_back(rec_t'{fx_req_stage, fx_req_ch, fx_req_data});

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // every active stage adds inc to each channel; bypassed stages pass through
  function automatic sample_t model(input sample_t din, input logic [NS-1:0] m, input logic [23:0] inc);
    sample_t r;
    int n = 0;
    for (int s = 0; s < NS; s++) if (!m[s]) n++;
    r.lc = din.lc + 24'(n) * inc;
    r.rc = din.rc + 24'(n) * inc;
    return r;
  endfunction

  task automatic check_log(input string tag, input sample_t din, input logic [NS-1:0] m, input logic [23:0] inc);
    rec_t q[$];
    int k = 0;
    for (int s = 0; s < NS; s++) if (!m[s]) begin
      q.push_back(rec_t'{STG_W'(s), 1'b0, din.lc + 24'(k) * inc});
      q.push_back(rec_t'{STG_W'(s), 1'b1, din.rc + 24'(k) * inc});
      k++;
    end
    chk({tag, "_nreq"}, 64'(rlog.size()), 64'(q.size()));
    for (int i = 0; i < q.size() && i < rlog.size(); i++)
      chk($sformatf("%s_req%0d", tag, i), 64'(rlog[i]), 64'(q[i]));
  endtask

  task automatic send_rx(input sample_t d, input logic [NS-1:0] m);
    @(negedge mclk);
    rx_data = d; bypass_mask = m; rx_vld = 1'b1;
    @(negedge mclk);
    rx_vld = 1'b0;
  endtask

  // called right after send_rx; k counts cycles since the rx_vld cycle
  task automatic wait_tx(input string tag, input sample_t exp, input bit exp_to, input bit exp_err);
    int k = 1;
    bit err_seen = 1'b0;
    while (1) begin
      if (frame_err) err_seen = 1'b1;
      if (tx_vld || k >= SLOT + 40) break;
      @(negedge mclk);
      k++;
    end
    chk({tag, "_lat"}, 64'(k), 64'(SLOT));
    chk({tag, "_tx"}, 64'(tx_data), 64'(exp));
    chk({tag, "_to"}, 64'(timeout), 64'(exp_to));
    chk({tag, "_ferr"}, 64'(err_seen), 64'(exp_err));
  endtask

  sample_t d, da, db;
  logic [NS-1:0] m;
  rec_t h;
  int w, unstable, nlog;

  initial begin
    repeat (3) @(negedge mclk);
    chk("reset_outs", 64'({tx_data, tx_vld, fx_req_vld, busy, timeout, frame_err, fx_req_stage, fx_req_ch}), 64'(0));
    chk("reset_req_data", 64'(fx_req_data), 64'(0));
    rst = 1'b0;
    repeat (2) @(negedge mclk);

    // all stages bypassed: frame passes through unchanged, no engine traffic
    rlog.delete();
    d = '{lc: 24'h123456, rc: 24'hABCDEF};
    send_rx(d, 4'hF);
    wait_tx("t1", d, 1'b0, 1'b0);
    chk("t1_nreq", 64'(rlog.size()), 64'(0));

    // full chain, engine +1 with 3-cycle latency
    rlog.delete();
    eng_lat = 3; eng_inc = 24'd1;
    send_rx(d, 4'h0);
    wait_tx("t2", '{lc: 24'h12345A, rc: 24'hABCDF3}, 1'b0, 1'b0);
    check_log("t2", d, 4'h0, 24'd1);

    // stages 0,2 bypassed, engine stalls the first request for 100 cycles
    rlog.delete();
    d = '{lc: 24'h00FFFF, rc: 24'hFFFFFF};
    rdy_dir = 1'b0;
    w = 0; unstable = 0;
    fork
      begin
        send_rx(d, 4'b0101);
        wait_tx("t3", '{lc: 24'h010001, rc: 24'h000001}, 1'b0, 1'b0);
      end
      begin
        while (!fx_req_vld && w < 100) begin @(negedge mclk); w++; end
        chk("t3_req_seen", 64'(fx_req_vld), 64'(1));
        h = rec_t'{fx_req_stage, fx_req_ch, fx_req_data};
        repeat (100) begin
          @(negedge mclk);
          if ({fx_req_vld, fx_req_stage, fx_req_ch, fx_req_data} !== {1'b1, h}) unstable++;
        end
        chk("t3_hold", 64'(unstable), 64'(0));
        chk("t3_first_req", 64'(h), 64'(rec_t'{3'd1, 1'b0, 24'h00FFFF}));
        rdy_dir = 1'b1;
      end
    join
    check_log("t3", d, 4'b0101, 24'd1);

    // engine too slow: deadline hit, dry frame out, late response drained
    rlog.delete();
    eng_lat = 100;
    d = '{lc: 24'h0A0B0C, rc: 24'h0D0E0F};
    send_rx(d, 4'h0);
    wait_tx("t4", d, 1'b1, 1'b0);
    chk("t4_draining", 64'(busy), 64'(1));
    nlog = rlog.size();
    w = 0;
    while (busy && w < 200) begin @(negedge mclk); w++; end
    chk("t4_drain_end", 64'(busy), 64'(0));
    chk("t4_no_new_req", 64'(rlog.size()), 64'(nlog));
    rlog.delete();
    eng_lat = 3;
    send_rx(d, 4'h0);
    wait_tx("t4b", model(d, 4'h0, 24'd1), 1'b0, 1'b0);
    check_log("t4b", d, 4'h0, 24'd1);

    // reset while a job is outstanding
    rlog.delete();
    eng_lat = 20;
    send_rx(d, 4'h0);
    w = 0;
    while (rlog.size() == 0 && w < 50) begin @(negedge mclk); w++; end
    chk("t5_hs", 64'(rlog.size()), 64'(1));
    repeat (2) @(negedge mclk);
    rst = 1'b1;
    @(negedge mclk);
    chk("t5_rst_outs", 64'({tx_data, tx_vld, fx_req_vld, busy, timeout, frame_err}), 64'(0));
    rst = 1'b0;
    @(negedge mclk); stray = 1'b1;
    @(negedge mclk); stray = 1'b0;
    unstable = 0;
    repeat (SLOT + 10) begin
      @(negedge mclk);
      if (tx_vld || busy || fx_req_vld || timeout || frame_err) unstable++;
    end
    chk("t5_quiet", 64'(unstable), 64'(0));
    rlog.delete();
    eng_lat = 3;
    send_rx(d, 4'h0);
    wait_tx("t5b", model(d, 4'h0, 24'd1), 1'b0, 1'b0);

    // second rx_vld 300 cycles in: first frame dropped, timing follows the second
    da = '{lc: 24'h111111, rc: 24'h222222};
    db = '{lc: 24'h333333, rc: 24'h444444};
    send_rx(da, 4'h0);
    unstable = 0;
    repeat (298) begin
      @(negedge mclk);
      if (tx_vld || frame_err) unstable++;
    end
    chk("t6_quiet", 64'(unstable), 64'(0));
    rlog.delete();
    send_rx(db, 4'h0);
    wait_tx("t6", model(db, 4'h0, 24'd1), 1'b0, 1'b1);
    check_log("t6", db, 4'h0, 24'd1);

    // randomized frames: random data, mask, increment, latency and ready
    rdy_rnd_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      rlog.delete();
      d       = sample_t'({$urandom, $urandom});
      m       = NS'($urandom);
      eng_lat = int'($urandom_range(1, 8));
      eng_inc = 24'($urandom);
      send_rx(d, m);
      wait_tx($sformatf("rnd%0d", i), model(d, m, eng_inc), 1'b0, 1'b0);
      check_log($sformatf("rnd%0d", i), d, m, eng_inc);
    end
    rdy_rnd_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
